// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer beside ID: load-use bubbles, branch flushes and memory-wait freeze.
// Define HAZARD_PERF_EN to build the stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter int LU_STALL_CYC = 1,
    parameter int FLUSH_CYC    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_to_reg,
    input  logic              ex_reg_write,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              stage_hold,
    output logic [1:0]        state_o,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    // Counter reload values: cnt holds the number of further cycles to spend in the state.
    localparam logic [1:0] LU_RELOAD    = 2'((LU_STALL_CYC > 1) ? (LU_STALL_CYC - 2) : 0);
    localparam logic [1:0] FLUSH_RELOAD = 2'((FLUSH_CYC > 0) ? (FLUSH_CYC - 1) : 0);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic       lu_s;
    logic       mem_busy_s;
    logic       pc_we_s;
    logic       ifid_we_s;
    logic       flush_s;
    logic       bubble_s;
    logic       hold_s;

    assign lu_s = ex_mem_to_reg & ex_reg_write &
                  ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
    assign mem_busy_s = dmem_req & ~dmem_ready;

    // Next-state, counter and pipeline-control decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pc_we_s     = 1'b1;
        ifid_we_s   = 1'b1;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        hold_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_busy_s) begin
                    pc_we_s     = 1'b0;
                    ifid_we_s   = 1'b0;
                    hold_s      = 1'b1;
                    state_nxt_s = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    // A coincident load-use is wrong-path, so the branch wins outright.
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (FLUSH_CYC > 0) begin
                        cnt_nxt_s   = FLUSH_RELOAD;
                        state_nxt_s = FLUSH;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (lu_s) begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    bubble_s  = 1'b1;
                    if (LU_STALL_CYC > 1) begin
                        cnt_nxt_s   = LU_RELOAD;
                        state_nxt_s = LU_STALL;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LU_STALL: begin
                if (mem_busy_s) begin
                    pc_we_s     = 1'b0;
                    ifid_we_s   = 1'b0;
                    hold_s      = 1'b1;
                    state_nxt_s = MEM_WAIT;
                end else begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    bubble_s  = 1'b1;
                    if (cnt_r == 2'd0) begin
                        state_nxt_s = RUN;
                    end else begin
                        cnt_nxt_s = cnt_r - 2'd1;
                    end
                end
            end
            FLUSH: begin
                flush_s  = 1'b1;
                bubble_s = 1'b1;
                if (ex_branch_taken) begin
                    cnt_nxt_s = FLUSH_RELOAD;
                end else if (cnt_r == 2'd0) begin
                    state_nxt_s = RUN;
                end else begin
                    cnt_nxt_s = cnt_r - 2'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    // cnt is left frozen so an interrupted load-use stall resumes.
                    state_nxt_s = (cnt_r != 2'd0) ? LU_STALL : RUN;
                end else begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    hold_s    = 1'b1;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = 2'd0;
                pc_we_s     = 1'b0;
                ifid_we_s   = 1'b0;
                flush_s     = 1'b1;
                bubble_s    = 1'b1;
            end
        endcase
    end

    // State and sequencing-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output stage: force NOP-loading values while reset is held
    always_comb begin
        if (reset) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            stage_hold     = 1'b0;
            state_o        = RUN;
        end else begin
            pc_write_en    = pc_we_s;
            if_id_write_en = ifid_we_s;
            if_id_flush    = flush_s;
            id_ex_bubble   = bubble_s;
            stage_hold     = hold_s;
            state_o        = state_r;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        branch_acc_s;

    assign branch_acc_s = ex_branch_taken &
                          (((state_r == RUN) & ~mem_busy_s) | (state_r == FLUSH));

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (!pc_we_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (branch_acc_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles = reset ? 32'd0 : stall_cnt_r;
    assign flush_events = reset ? 32'd0 : flush_cnt_r;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LU=1/FLUSH=1 and LU=2/FLUSH=0) against an owed-cycles model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [3:0] id_rn = 4'd0, id_rm = 4'd0, ex_rd = 4'd0;
    logic       id_uses_rn = 1'b0, id_uses_rm = 1'b0;
    logic       ex_mem_to_reg = 1'b0, ex_reg_write = 1'b0, ex_branch_taken = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;

    logic [1:0]  pc_w, ifid_w, flush_w, bub_w, hold_w;
    logic [1:0]  st [2];
    logic [31:0] sc [2];
    logic [31:0] fe [2];

    pipeline_hazard_ctrl #(.REG_AW(4), .LU_STALL_CYC(1), .FLUSH_CYC(1)) dut_a (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_w[0]), .if_id_write_en(ifid_w[0]), .if_id_flush(flush_w[0]),
        .id_ex_bubble(bub_w[0]), .stage_hold(hold_w[0]), .state_o(st[0]),
        .stall_cycles(sc[0]), .flush_events(fe[0])
    );

    pipeline_hazard_ctrl #(.REG_AW(4), .LU_STALL_CYC(2), .FLUSH_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write_en(pc_w[1]), .if_id_write_en(ifid_w[1]), .if_id_flush(flush_w[1]),
        .id_ex_bubble(bub_w[1]), .stage_hold(hold_w[1]), .state_o(st[1]),
        .stall_cycles(sc[1]), .flush_events(fe[1])
    );

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Model: per instance, extra stall cycles owed, extra flush cycles owed, frozen flag.
    int          p_lu [2] = '{1, 2};
    int          p_fl [2] = '{1, 0};
    int          m_stall [2] = '{0, 0};
    int          m_flush [2] = '{0, 0};
    bit          m_wait  [2] = '{1'b0, 1'b0};
    int unsigned m_sc [2] = '{0, 0};
    int unsigned m_fe [2] = '{0, 0};
    int          m_kind;   // 0 decode, 1 freeze, 2 flush, 3 stall, 4 reset
    bit          m_acc, m_busy, m_lu;
    logic [1:0]  m_st;
    logic [31:0] e_sc, e_fe;

    always @(negedge clk) begin
        if (check_en) begin
            m_busy = dmem_req && !dmem_ready;
            m_lu = ex_mem_to_reg && ex_reg_write &&
                   ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
            for (int i = 0; i < 2; i++) begin
                m_acc = 1'b0;
                if (reset) m_kind = 4;
                else if (m_wait[i]) m_kind = dmem_ready ? 0 : 1;
                else if (m_flush[i] > 0) begin m_kind = 2; m_acc = ex_branch_taken; end
                else if (m_stall[i] > 0) m_kind = m_busy ? 1 : 3;
                else if (m_busy) m_kind = 1;
                else if (ex_branch_taken) begin m_kind = 2; m_acc = 1'b1; end
                else if (m_lu) m_kind = 3;
                else m_kind = 0;

                if (reset) m_st = 2'd0;
                else if (m_wait[i]) m_st = 2'd3;
                else if (m_flush[i] > 0) m_st = 2'd2;
                else if (m_stall[i] > 0) m_st = 2'd1;
                else m_st = 2'd0;
`ifdef HAZARD_PERF_EN
                e_sc = reset ? 32'd0 : m_sc[i];
                e_fe = reset ? 32'd0 : m_fe[i];
`else
                e_sc = 32'd0;
                e_fe = 32'd0;
`endif
                check("pc_write_en", i, pc_w[i], (m_kind == 0 || m_kind == 2));
                check("if_id_write_en", i, ifid_w[i], (m_kind == 0 || m_kind == 2));
                check("if_id_flush", i, flush_w[i], (m_kind == 2 || m_kind == 4));
                check("id_ex_bubble", i, bub_w[i], (m_kind >= 2));
                check("stage_hold", i, hold_w[i], (m_kind == 1));
                check("state_o", i, st[i], m_st);
                check("stall_cycles", i, sc[i], e_sc);
                check("flush_events", i, fe[i], e_fe);

                if (reset) begin
                    m_wait[i] = 1'b0; m_flush[i] = 0; m_stall[i] = 0; m_sc[i] = 0; m_fe[i] = 0;
                end else begin
                    if ((m_kind == 1 || m_kind == 3) && m_sc[i] != 32'hFFFF_FFFF) m_sc[i]++;
                    if (m_acc && m_fe[i] != 32'hFFFF_FFFF) m_fe[i]++;
                    if (m_wait[i]) begin
                        if (dmem_ready) begin
                            m_wait[i] = 1'b0;
                            if (m_stall[i] == 1) m_stall[i] = 0;
                        end
                    end else if (m_flush[i] > 0) begin
                        if (ex_branch_taken) m_flush[i] = p_fl[i];
                        else m_flush[i]--;
                    end else if (m_stall[i] > 0) begin
                        if (m_busy) m_wait[i] = 1'b1;
                        else m_stall[i]--;
                    end else if (m_busy) m_wait[i] = 1'b1;
                    else if (ex_branch_taken) m_flush[i] = p_fl[i];
                    else if (m_lu) m_stall[i] = p_lu[i] - 1;
                end
            end
        end
    end

    // Drive one cycle of inputs just after the clock edge; returns mid-cycle for literal checks.
    task automatic drive(input logic rst, input logic br, input logic dreq, input logic drdy,
                         input logic mtr, input logic wr, input logic [3:0] rd,
                         input logic [3:0] rn, input logic un, input logic [3:0] rm, input logic um);
        @(posedge clk);
        #1;
        reset = rst; ex_branch_taken = br; dmem_req = dreq; dmem_ready = drdy;
        ex_mem_to_reg = mtr; ex_reg_write = wr; ex_rd = rd;
        id_rn = rn; id_uses_rn = un; id_rm = rm; id_uses_rm = um;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        check_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("rst_pc", 0, pc_w[0], 1'b0);
        check("rst_flush", 0, flush_w[0], 1'b1);
        check("rst_bubble", 0, bub_w[0], 1'b1);
        check("rst_state", 0, st[0], 2'd0);
        idle();
        check("idle_pc", 0, pc_w[0], 1'b1);

        // Load r3 in EX, ID reads r3 via rn
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0);
        check("lu_pc", 0, pc_w[0], 1'b0);
        check("lu_bubble", 0, bub_w[0], 1'b1);
        check("lu_pc", 1, pc_w[1], 1'b0);
        idle();
        check("lu_after_pc", 0, pc_w[0], 1'b1);
        check("lu2_pc", 1, pc_w[1], 1'b0);
        check("lu2_state", 1, st[1], 2'd1);
        idle();
        check("lu2_done_pc", 1, pc_w[1], 1'b1);
        check("lu2_done_state", 1, st[1], 2'd0);

        // Matching reg but operand not used / no register write -> no hazard
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 4'd5, 1'b0);
        check("nouse_pc", 0, pc_w[0], 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0);
        check("nowr_pc", 0, pc_w[0], 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd0, 1'b1, 4'd7, 1'b1);
        idle();

        // Taken branch pulse
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("br_flush", 0, flush_w[0], 1'b1);
        check("br_pc", 0, pc_w[0], 1'b1);
        idle();
        check("br_flush2", 0, flush_w[0], 1'b1);
        check("br_state2", 0, st[0], 2'd2);
        check("br_noflush", 1, flush_w[1], 1'b0);
        idle();
        check("br_end_flush", 0, flush_w[0], 1'b0);
`ifdef HAZARD_PERF_EN
        check("br_flush_events", 0, fe[0], 32'd1);
`endif
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) idle();

        // Memory wait with a taken branch presented throughout
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
            check("mw_hold", 0, hold_w[0], 1'b1);
            check("mw_noflush", 0, flush_w[0], 1'b0);
        end
        check("mw_state", 0, st[0], 2'd3);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("rel_hold", 0, hold_w[0], 1'b0);
        check("rel_noflush", 0, flush_w[0], 1'b0);
        check("rel_pc", 0, pc_w[0], 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("rel1_flush", 0, flush_w[0], 1'b1);
        idle();
        idle();

        // Branch and load-use together -> flush only
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0);
        check("brlu_flush", 0, flush_w[0], 1'b1);
        check("brlu_bubble", 0, bub_w[0], 1'b1);
        check("brlu_pc", 0, pc_w[0], 1'b1);
        check("brlu_pc", 1, pc_w[1], 1'b1);
        idle();
        idle();

        // Memory wait interrupting a multi-cycle load-use stall
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0, 4'd2, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("lumw_hold", 1, hold_w[1], 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        idle();
        check("lumw_state", 1, st[1], 2'd0);
        idle();

        // Reset asserted while in FLUSH
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        check("rstfl_state", 0, st[0], 2'd0);
        check("rstfl_pc", 0, pc_w[0], 1'b0);
        check("rstfl_flush", 0, flush_w[0], 1'b1);
        check("rstfl_fe", 0, fe[0], 32'd0);
        idle();
        check("rstfl_after_state", 0, st[0], 2'd0);
        check("rstfl_after_flush", 0, flush_w[0], 1'b0);

        // Mixed directed pattern exercising event overlaps
        for (int i = 0; i < 60; i++) begin
            drive((i == 40), (i % 7 == 3) || (i % 11 == 4), (i % 5 == 1) || (i % 5 == 2), (i % 5 == 2),
                  (i % 3 != 1), (i % 4 != 3), 4'(i % 4), 4'((i / 2) % 4), (i % 2 == 0),
                  4'((i + 1) % 4), (i % 3 == 0));
        end
        idle();
        idle();
        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
